// File: rtl/mc_ctrl_if.sv
// rtl/mc_ctrl_if.sv - memory request/acknowledge bus between mc_ctrl and the memory port
interface mc_ctrl_if;
  logic mem_req;
  logic mem_we;
  logic mem_ack;

  modport master (output mem_req, output mem_we, input mem_ack);
  modport slave  (input mem_req, input mem_we, output mem_ack);
endinterface

// File: rtl/mc_ctrl.sv
// rtl/mc_ctrl.sv - multicycle MIPS-subset control FSM; divu/DIV state enabled by MC_CTRL_DIV_EN
module mc_ctrl #(
  parameter int DIV_CYCLES = 32,
  parameter int TYPE_W     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  mc_ctrl_if.master         mem,
  input  logic [5:0]        opcode,
  input  logic [5:0]        func,
  input  logic              alu_zero,
  output logic              ir_we,
  output logic              pc_we,
  output logic              reg_we,
  output logic              hilo_we,
  output logic [1:0]        pc_src,
  output logic [3:0]        alu_op,
  output logic              alu_src_imm,
  output logic              ext_zero,
  output logic              reg_dst_rd,
  output logic              mem_to_reg,
  output logic              div_start,
  output logic [TYPE_W-1:0] inst_type,
  output logic              illegal,
  output logic [2:0]        state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_DIV    = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  typedef enum logic [3:0] {
    T_RSVD  = 4'd0,
    T_LUI   = 4'd1,
    T_ADDIU = 4'd2,
    T_ADDU  = 4'd3,
    T_SUBU  = 4'd4,
    T_LW    = 4'd5,
    T_SW    = 4'd6,
    T_BEQ   = 4'd7,
    T_J     = 4'd8,
    T_ORI   = 4'd9,
    T_DIVU  = 4'd10,
    T_SLL   = 4'd11,
    T_SRL   = 4'd12
  } itype_t;

  state_t     state_q, state_d;
  itype_t     it_q, dec;
  logic [3:0] mux_alu;
  logic       mux_imm, mux_zx;

  always_comb begin
    dec = T_RSVD;
    case (opcode)
      6'b000000: begin
        case (func)
          6'b100001: dec = T_ADDU;
          6'b100011: dec = T_SUBU;
          6'b000000: dec = T_SLL;
          6'b000010: dec = T_SRL;
`ifdef MC_CTRL_DIV_EN
          6'b011011: dec = T_DIVU;
`endif
          default:   dec = T_RSVD;
        endcase
      end
      6'b001111: dec = T_LUI;
      6'b001001: dec = T_ADDIU;
      6'b100011: dec = T_LW;
      6'b101011: dec = T_SW;
      6'b000100: dec = T_BEQ;
      6'b000010: dec = T_J;
      6'b001101: dec = T_ORI;
      default:   dec = T_RSVD;
    endcase
  end

  // Datapath mux settings depend only on the registered type, so they hold for a whole state.
  always_comb begin
    mux_alu = 4'd0;
    mux_imm = 1'b0;
    mux_zx  = 1'b0;
    case (it_q)
      T_LUI:              begin mux_alu = 4'd6; mux_imm = 1'b1; end
      T_ADDIU, T_LW, T_SW: begin mux_alu = 4'd1; mux_imm = 1'b1; end
      T_ADDU:             mux_alu = 4'd1;
      T_SUBU, T_BEQ:      mux_alu = 4'd2;
      T_ORI:              begin mux_alu = 4'd3; mux_imm = 1'b1; mux_zx = 1'b1; end
      T_SLL:              mux_alu = 4'd4;
      T_SRL:              mux_alu = 4'd5;
      default:            mux_alu = 4'd0;
    endcase
  end

`ifdef MC_CTRL_DIV_EN
  logic [7:0] div_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= 8'd0;
    end else if (state_q == S_EXEC && state_d == S_DIV) begin
      div_cnt <= 8'(DIV_CYCLES - 1);
    end else if (state_q == S_DIV && div_cnt != 8'd0) begin
      div_cnt <= div_cnt - 8'd1;
    end
  end
`else
  logic unused_div_cfg;
  assign unused_div_cfg = (DIV_CYCLES > 0);
`endif

  // Outputs are gated by rst_n so an asserted reset silences every strobe at once.
  always_comb begin
    state_d      = state_q;
    mem.mem_req  = 1'b0;
    mem.mem_we   = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    reg_we       = 1'b0;
    hilo_we      = 1'b0;
    div_start    = 1'b0;
    pc_src       = 2'd0;
    alu_op       = 4'd0;
    alu_src_imm  = 1'b0;
    ext_zero     = 1'b0;
    reg_dst_rd   = 1'b0;
    mem_to_reg   = 1'b0;
    if (rst_n) begin
      if (state_q inside {S_EXEC, S_MEM, S_WB}) begin
        alu_op      = mux_alu;
        alu_src_imm = mux_imm;
        ext_zero    = mux_zx;
      end
      case (state_q)
        S_FETCH: begin
          mem.mem_req = 1'b1;
          if (mem.mem_ack) begin
            ir_we   = 1'b1;
            pc_we   = 1'b1;
            state_d = S_DECODE;
          end
        end
        S_DECODE: state_d = (dec == T_RSVD) ? S_HALT : S_EXEC;
        S_EXEC: begin
          case (it_q)
            T_BEQ: begin
              pc_src  = 2'd1;
              pc_we   = alu_zero;
              state_d = S_FETCH;
            end
            T_J: begin
              pc_src  = 2'd2;
              pc_we   = 1'b1;
              state_d = S_FETCH;
            end
            T_LW, T_SW: state_d = S_MEM;
`ifdef MC_CTRL_DIV_EN
            T_DIVU: begin
              div_start = 1'b1;
              state_d   = S_DIV;
            end
`endif
            default: state_d = S_WB;
          endcase
        end
        S_MEM: begin
          mem.mem_req = 1'b1;
          mem.mem_we  = (it_q == T_SW);
          if (mem.mem_ack) state_d = (it_q == T_SW) ? S_FETCH : S_WB;
        end
        S_WB: begin
          reg_we     = 1'b1;
          reg_dst_rd = (it_q inside {T_ADDU, T_SUBU, T_SLL, T_SRL});
          mem_to_reg = (it_q == T_LW);
          state_d    = S_FETCH;
        end
`ifdef MC_CTRL_DIV_EN
        S_DIV: begin
          if (div_cnt == 8'd0) begin
            hilo_we = 1'b1;
            state_d = S_FETCH;
          end
        end
`endif
        S_HALT:  state_d = S_HALT;
        default: state_d = S_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      it_q    <= T_RSVD;
      illegal <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) begin
        it_q <= dec;
        if (dec == T_RSVD) illegal <= 1'b1;
      end
    end
  end

  assign inst_type = TYPE_W'(it_q);
  assign state     = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// tb/tb_mc_ctrl.sv - randomized self-checking bench for mc_ctrl using a per-cycle trace model
module tb_mc_ctrl;
  localparam int N_DIV = 4;
`ifdef MC_CTRL_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic [5:0] func = 6'd0;
  logic       alu_zero = 1'b0;
  logic       ir_we, pc_we, reg_we, hilo_we;
  logic [1:0] pc_src;
  logic [3:0] alu_op;
  logic       alu_src_imm, ext_zero, reg_dst_rd, mem_to_reg, div_start;
  logic [3:0] inst_type;
  logic       illegal;
  logic [2:0] state;
  logic       ack_r = 1'b0;

  int checks = 0;
  int errors = 0;

  mc_ctrl_if mif();
  assign mif.mem_ack = ack_r;

  mc_ctrl #(.DIV_CYCLES(N_DIV), .TYPE_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .mem(mif), .opcode(opcode), .func(func), .alu_zero(alu_zero),
    .ir_we(ir_we), .pc_we(pc_we), .reg_we(reg_we), .hilo_we(hilo_we), .pc_src(pc_src),
    .alu_op(alu_op), .alu_src_imm(alu_src_imm), .ext_zero(ext_zero), .reg_dst_rd(reg_dst_rd),
    .mem_to_reg(mem_to_reg), .div_start(div_start), .inst_type(inst_type), .illegal(illegal),
    .state(state)
  );

  always #5 clk = ~clk;

  // Memory responder: each request waits the next queued latency, then acks for one cycle.
  int  lat_q[$];
  bit  pend = 1'b0;
  int  cnt = 0;
  always @(posedge clk) begin
    #2;
    ack_r = 1'b0;
    if (!rst_n || !mif.mem_req) begin
      pend = 1'b0;
    end else begin
      if (!pend) begin
        pend = 1'b1;
        cnt  = (lat_q.size() > 0) ? lat_q.pop_front() : 0;
      end
      if (cnt == 0) begin
        ack_r = 1'b1;
        pend  = 1'b0;
      end else begin
        cnt--;
      end
    end
  end

  function automatic logic [19:0] pk(input logic [2:0] st, input logic req, input logic we,
                                     input logic irw, input logic pcw, input logic rw,
                                     input logic hw, input logic ds, input logic [1:0] ps,
                                     input logic [3:0] ao, input logic imm, input logic zx,
                                     input logic rd, input logic m2r);
    return {st, req, we, irw, pcw, rw, hw, ds, ps, ao, imm, zx, rd, m2r};
  endfunction

  function automatic logic [19:0] obs_vec();
    return pk(state, mif.mem_req, mif.mem_we, ir_we, pc_we, reg_we, hilo_we, div_start,
              pc_src, alu_op, alu_src_imm, ext_zero, reg_dst_rd, mem_to_reg);
  endfunction

  // Instruction table: encoding and the ALU/mux settings each type needs.
  task automatic attrs(input int t, output logic [5:0] op, output logic [5:0] fn,
                       output logic [3:0] ao, output logic imm, output logic zx, output logic rd);
    op = 6'd0; fn = 6'($urandom); ao = 4'd0; imm = 1'b0; zx = 1'b0; rd = 1'b0;
    case (t)
      1:  begin op = 6'b001111; ao = 4'd6; imm = 1'b1; end
      2:  begin op = 6'b001001; ao = 4'd1; imm = 1'b1; end
      3:  begin fn = 6'b100001; ao = 4'd1; rd = 1'b1; end
      4:  begin fn = 6'b100011; ao = 4'd2; rd = 1'b1; end
      5:  begin op = 6'b100011; ao = 4'd1; imm = 1'b1; end
      6:  begin op = 6'b101011; ao = 4'd1; imm = 1'b1; end
      7:  begin op = 6'b000100; ao = 4'd2; end
      8:  op = 6'b000010;
      9:  begin op = 6'b001101; ao = 4'd3; imm = 1'b1; zx = 1'b1; end
      10: fn = 6'b011011;
      11: begin fn = 6'b000000; ao = 4'd4; rd = 1'b1; end
      12: begin fn = 6'b000010; ao = 4'd5; rd = 1'b1; end
      default: op = 6'b111111;
    endcase
  endtask

  // Builds the expected cycle trace for one instruction and checks the DUT against it.
  task automatic run_instr(input int t, input int fl, input int ml, input logic z, input int stop_after);
    logic [19:0] exp_q[$];
    logic [19:0] obs;
    logic [5:0]  op, fn;
    logic [3:0]  ao;
    logic        imm, zx, rd;
    bit          halt;
    int          n;
    attrs(t, op, fn, ao, imm, zx, rd);
    halt = (t == 0) || (t == 10 && !DIV_EN);
    opcode = op; func = fn; alu_zero = z;
    for (int i = 0; i < fl; i++) exp_q.push_back(pk(3'd0, 1, 0, 0, 0, 0, 0, 0, 2'd0, 4'd0, 0, 0, 0, 0));
    exp_q.push_back(pk(3'd0, 1, 0, 1, 1, 0, 0, 0, 2'd0, 4'd0, 0, 0, 0, 0));
    exp_q.push_back(pk(3'd1, 0, 0, 0, 0, 0, 0, 0, 2'd0, 4'd0, 0, 0, 0, 0));
    if (halt) begin
      for (int i = 0; i < 20; i++) exp_q.push_back(pk(3'd6, 0, 0, 0, 0, 0, 0, 0, 2'd0, 4'd0, 0, 0, 0, 0));
    end else begin
      exp_q.push_back(pk(3'd2, 0, 0, 0, (t == 7) ? z : (t == 8), 0, 0, (t == 10),
                         (t == 7) ? 2'd1 : ((t == 8) ? 2'd2 : 2'd0), ao, imm, zx, 0, 0));
      if (t == 5 || t == 6)
        for (int i = 0; i <= ml; i++) exp_q.push_back(pk(3'd3, 1, (t == 6), 0, 0, 0, 0, 0, 2'd0, ao, imm, zx, 0, 0));
      if (t == 10)
        for (int i = 0; i < N_DIV; i++) exp_q.push_back(pk(3'd5, 0, 0, 0, 0, 0, (i == N_DIV - 1), 0, 2'd0, 4'd0, 0, 0, 0, 0));
      else if (!(t inside {6, 7, 8}))
        exp_q.push_back(pk(3'd4, 0, 0, 0, 0, 1, 0, 0, 2'd0, ao, imm, zx, rd, (t == 5)));
    end
    lat_q.push_back(fl);
    if (t == 5 || t == 6) lat_q.push_back(ml);
    n = (stop_after >= 0 && stop_after < exp_q.size()) ? stop_after : exp_q.size();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      obs = obs_vec();
      checks++;
      if (obs !== exp_q[i]) begin
        errors++;
        $display("FAIL trace type=%0d cyc=%0d got=%h exp=%h", t, i, obs, exp_q[i]);
      end
      if (exp_q[i][19:17] == 3'd2) begin
        checks++;
        if (inst_type !== 4'(t)) begin
          errors++;
          $display("FAIL inst_type type=%0d got=%0d exp=%0d", t, inst_type, t);
        end
      end
      if (exp_q[i][19:17] == 3'd6) begin
        checks++;
        if (illegal !== 1'b1 || inst_type !== 4'd0) begin
          errors++;
          $display("FAIL halt_flags illegal=%b inst_type=%0d exp illegal=1 inst_type=0", illegal, inst_type);
        end
      end
    end
  endtask

  task automatic pulse_reset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (state !== 3'd0 || illegal !== 1'b0 || inst_type !== 4'd0 || obs_vec() !== 20'd0) begin
      errors++;
      $display("FAIL reset_%s state=%0d illegal=%b inst_type=%0d outs=%h exp 0/0/0/0", tag, state, illegal, inst_type, obs_vec());
    end
    lat_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    checks++;
    if (state !== 3'd0 || illegal !== 1'b0 || inst_type !== 4'd0 || obs_vec() !== 20'd0) begin
      errors++;
      $display("FAIL reset_init state=%0d illegal=%b inst_type=%0d outs=%h exp all 0", state, illegal, inst_type, obs_vec());
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_addu();
    run_instr(3, 0, 0, 1'b0, -1);
  endtask

  task automatic test_lw_delay();
    run_instr(5, 0, 3, 1'b0, -1);
    run_instr(6, 1, 2, 1'b0, -1);
  endtask

  task automatic test_beq();
    run_instr(7, 0, 0, 1'b0, -1);
    run_instr(7, 0, 0, 1'b1, -1);
    run_instr(8, 2, 0, 1'b0, -1);
  endtask

  task automatic test_random();
    int t;
    for (int k = 0; k < 30; k++) begin
      t = $urandom_range(1, 12);
      if (!DIV_EN && t == 10) t = 9;
      run_instr(t, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), -1);
    end
  endtask

  task automatic test_divu();
    run_instr(10, 0, 0, 1'b0, -1);
`ifndef MC_CTRL_DIV_EN
    pulse_reset("divu_halt");
`endif
  endtask

  task automatic test_reset_mid_mem();
    run_instr(5, 0, 10, 1'b0, 5);
    pulse_reset("mid_mem");
    run_instr(3, 0, 0, 1'b0, -1);
  endtask

`ifdef MC_CTRL_DIV_EN
  task automatic test_reset_mid_div();
    run_instr(10, 0, 0, 1'b0, 5);
    pulse_reset("mid_div");
    run_instr(4, 0, 0, 1'b0, -1);
  endtask
`endif

  task automatic test_illegal_halt();
    run_instr(0, 1, 0, 1'b0, -1);
    pulse_reset("halt");
    run_instr(11, 0, 0, 1'b0, -1);
  endtask

  initial begin
    test_reset();
    test_addu();
    test_lw_delay();
    test_beq();
    test_random();
    test_divu();
    test_reset_mid_mem();
`ifdef MC_CTRL_DIV_EN
    test_reset_mid_div();
`endif
    test_illegal_halt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 SHALL have parameter DIV_CYCLES, default 32: number of cycles spent in DIV state; legal range 1..255.
REQ-002 SHALL have parameter TYPE_W, default 4: width of inst_type encoding.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port opcode  input  6  instruction bits [31:26] from IR.
REQ-006 SHALL have port func  input  6  instruction bits [5:0] from IR.
REQ-007 SHALL have port alu_zero  input  1  ALU equality result for beq.
REQ-008 SHALL have port mem_ack  input  1  memory completion, one-cycle pulse.
REQ-009 SHALL have port mem_req, mem_we  output  1 each  memory request and write qualifier.
REQ-010 SHALL have port ir_we, pc_we, reg_we, hilo_we  output  1 each  register-load strobes.
REQ-011 SHALL have port pc_src  output  2  0=PC+4, 1=branch target, 2=jump target.
REQ-012 SHALL have port alu_op  output  4  1=add, 2=sub, 3=or, 4=sll, 5=srl, 6=lui-shift.
REQ-013 SHALL have port alu_src_imm, ext_zero, reg_dst_rd, mem_to_reg  output  1 each  datapath muxes.
REQ-014 SHALL have port div_start  output  1  one-cycle divider start pulse.
REQ-015 SHALL have port inst_type  output  TYPE_W  registered decode: 0 reserved, 1 lui, 2 addiu, 3 addu, 4 subu, 5 lw, 6 sw, 7 beq, 8 j, 9 ori, 10 divu, 11 sll, 12 srl.
REQ-016 SHALL have port illegal, state  output  1, 3  sticky illegal-instruction flag; current FSM state.

Function
REQ-017 SHALL decode opcode 000000 by func only (100001 addu, 100011 subu, 011011 divu, 000000 sll, 000010 srl); other func -> reserved; I/J opcodes 001111, 001001, 100011, 101011, 000100, 000010, 001101 -> lui, addiu, lw, sw, beq, j, ori; others -> reserved.
REQ-018 SHALL implement states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, DIV=5, HALT=6.
REQ-019 FETCH: mem_req=1, mem_we=0 until mem_ack; ack cycle asserts ir_we=1, pc_we=1, pc_src=0, next DECODE.
REQ-020 DECODE: registers inst_type; reserved -> illegal=1, next HALT; otherwise next EXEC.
REQ-021 EXEC: beq drives alu_op=sub, pc_src=1, pc_we=alu_zero, next FETCH; j drives pc_we=1, pc_src=2, next FETCH; lw/sw -> MEM; divu pulses div_start, next DIV; all others -> WB.
REQ-022 MEM: mem_req=1, mem_we=1 for sw; on mem_ack sw -> FETCH, lw -> WB.
REQ-023 WB: reg_we=1 for exactly one cycle; reg_dst_rd=1 for addu/subu/sll/srl; mem_to_reg=1 for lw; next FETCH.
REQ-024 DIV: counter loads DIV_CYCLES-1 on entry, decrements each cycle; at zero pulses hilo_we, next FETCH.
REQ-025 ext_zero=1 for ori only; alu_src_imm=1 for lui, addiu, ori, lw, sw; mux outputs held stable for whole state.
REQ-026 SHALL accept mem_ack in the same cycle mem_req rises (zero-wait); mem_ack outside FETCH/MEM ignored.
REQ-027 Latency with zero-wait memory: beq/j 3 cycles, sw/ALU ops 4, lw 5, divu 3+DIV_CYCLES.
REQ-028 HALT: all strobes and mem_req 0; exits only via reset.
REQ-029 DIV_CYCLES=1: DIV lasts one cycle, hilo_we in that cycle.

Reset
REQ-030 rst_n low SHALL immediately force state=FETCH, inst_type=0, illegal=0, counter=0, all strobes, mem_req, div_start 0, pc_src=0, alu_op=0.
REQ-031 Reset asserted mid-MEM or mid-DIV SHALL abandon operation; no reg_we/hilo_we afterwards; first cycle after release is FETCH with mem_req=1.

Configuration
REQ-032 Macro MC_CTRL_DIV_EN defined: divu decoded and DIV state used as above.
REQ-033 MC_CTRL_DIV_EN undefined: func 011011 decodes reserved (illegal, HALT); DIV state, counter and DIV_CYCLES unused; div_start, hilo_we tied 0.

Verification
REQ-034 addu (op 0, func 100001), ack in request cycle -> FETCH,DECODE,EXEC,WB; reg_we one cycle with reg_dst_rd=1; back in FETCH at cycle 4.
REQ-035 lw, data ack delayed 3 cycles -> mem_req held 4 MEM cycles, mem_we=0, then WB with mem_to_reg=1.
REQ-036 beq with alu_zero=0 then =1 -> pc_we 0 then 1 in EXEC, pc_src=1 both times.
REQ-037 divu, DIV_CYCLES=4, MC_CTRL_DIV_EN set -> div_start one pulse, 4 DIV cycles, hilo_we on 4th; unset -> illegal=1, state=6.
REQ-038 op 111111 -> illegal=1, HALT, strobes 0 for 20 cycles; rst_n low -> state=0, illegal=0 asynchronously.
